// File: rtl/ola_trigger_ctl_writer.sv
// Serial loader for the trigger state registers: queued parallel commands are sent LSB-first on ctl_*.
// Latency: enable rises one cycle after a command is accepted into an idle, empty writer; cmd_ready falls only when the FIFO is full.
module ola_trigger_ctl_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [width-1:0] i_dat,
  input  logic             i_pop,
  output logic [width-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(depth));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dat   = r_mem[r_rd];

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_dat;
  end
endmodule

module ola_trigger_ctl_writer #(
  parameter int data_width = 32,
  parameter int len_width  = 8,
  parameter int sel_width  = 2,
  parameter int reg_width  = 2,
  parameter int fifo_depth = 4,
  parameter int gap_cycles = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [data_width-1:0] cmd_data,
  input  logic [len_width-1:0]  cmd_len,
  input  logic [sel_width-1:0]  cmd_which,
  input  logic [reg_width-1:0]  cmd_what,
  output logic                  ctl_enable,
  output logic                  ctl_data,
  output logic [sel_width-1:0]  ctl_state_which,
  output logic [reg_width-1:0]  ctl_state_what,
  output logic                  busy,
  output logic                  done,
  output logic                  err_len
);
  localparam int GW = (gap_cycles > 1) ? $clog2(gap_cycles) : 1;
  localparam int CW = data_width + len_width + sel_width + reg_width;

  typedef struct packed {
    logic [data_width-1:0] data;
    logic [len_width-1:0]  len;
    logic [sel_width-1:0]  which;
    logic [reg_width-1:0]  what;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t                r_state, w_state_nxt;
  logic [data_width-1:0] r_shift, w_shift_nxt;
  logic [len_width-1:0]  r_cnt, w_cnt_nxt;
  logic [GW-1:0]         r_gap, w_gap_nxt;
  logic                  w_en_nxt, w_dat_nxt, w_done_nxt, w_err_nxt;
  logic [sel_width-1:0]  w_which_nxt;
  logic [reg_width-1:0]  w_what_nxt;
  logic                  w_pop, w_full, w_empty, w_len_ok;
  cmd_t                  w_in, w_head;
  logic [CW-1:0]         w_head_bits;

  assign w_in = '{data: cmd_data, len: cmd_len, which: cmd_which, what: cmd_what};

  ola_trigger_ctl_fifo #(.width(CW), .depth(fifo_depth)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (cmd_valid),
    .i_dat   (w_in),
    .i_pop   (w_pop),
    .o_dat   (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head    = cmd_t'(w_head_bits);
  assign cmd_ready = !w_full;
  assign busy      = !w_empty || (r_state != S_IDLE);
  // Full-width compare: oversized lengths are rejected, never truncated.
  assign w_len_ok  = (w_head.len != '0) && (w_head.len <= len_width'(data_width));

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_en_nxt    = 1'b0;
    w_dat_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_which_nxt = ctl_state_which;
    w_what_nxt  = ctl_state_what;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_len_ok) begin
            w_shift_nxt = w_head.data;
            w_cnt_nxt   = w_head.len - len_width'(1);
            w_dat_nxt   = w_head.data[0];
            w_en_nxt    = 1'b1;
            w_which_nxt = w_head.which;
            w_what_nxt  = w_head.what;
            w_state_nxt = S_SHIFT;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (r_cnt != '0) begin
          w_shift_nxt = r_shift >> 1;
          w_dat_nxt   = r_shift[1];
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = r_cnt - len_width'(1);
        end else begin
          w_done_nxt  = 1'b1;
          w_gap_nxt   = GW'(gap_cycles - 1);
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap == '0) w_state_nxt = S_IDLE;
        else             w_gap_nxt   = r_gap - GW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_shift         <= '0;
      r_cnt           <= '0;
      r_gap           <= '0;
      ctl_enable      <= 1'b0;
      ctl_data        <= 1'b0;
      ctl_state_which <= '0;
      ctl_state_what  <= '0;
      done            <= 1'b0;
      err_len         <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_shift         <= w_shift_nxt;
      r_cnt           <= w_cnt_nxt;
      r_gap           <= w_gap_nxt;
      ctl_enable      <= w_en_nxt;
      ctl_data        <= w_dat_nxt;
      ctl_state_which <= w_which_nxt;
      ctl_state_what  <= w_what_nxt;
      done            <= w_done_nxt;
      err_len         <= w_err_nxt;
    end
  end
endmodule

// File: tb/tb_ola_trigger_ctl_writer.sv
// Bench for ola_trigger_ctl_writer: directed commands feed an expectation queue; a negedge monitor rebuilds frames and error pulses and checks them.
module tb_ola_trigger_ctl_writer;
  localparam int GAP = 1;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic [7:0]  cmd_len;
  logic [1:0]  cmd_which;
  logic [1:0]  cmd_what;
  logic        ctl_enable;
  logic        ctl_data;
  logic [1:0]  ctl_state_which;
  logic [1:0]  ctl_state_what;
  logic        busy;
  logic        done;
  logic        err_len;

  ola_trigger_ctl_writer #(
    .data_width(32), .len_width(8), .sel_width(2), .reg_width(2),
    .fifo_depth(4), .gap_cycles(GAP)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_len(cmd_len), .cmd_which(cmd_which), .cmd_what(cmd_what),
    .ctl_enable(ctl_enable), .ctl_data(ctl_data),
    .ctl_state_which(ctl_state_which), .ctl_state_what(ctl_state_what),
    .busy(busy), .done(done), .err_len(err_len)
  );

  typedef struct {
    int          kind;
    logic [63:0] data;
    int          len;
    logic [1:0]  which;
    logic [1:0]  what;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   frames_seen = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor state
  bit          in_frame = 0;
  bit          have_prev = 0;
  bit          stable = 1;
  int          low_run = 0;
  int          f_len = 0;
  logic [63:0] f_data = '0;
  logic [1:0]  f_which = '0;
  logic [1:0]  f_what = '0;

  task automatic pop_cmp(input int kind, input logic [63:0] d, input int l,
                         input logic [1:0] wh, input logic [1:0] wt);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_event", 64'(kind), 64'(0));
      return;
    end
    e = q.pop_front();
    chk("event_kind", 64'(kind), 64'(e.kind));
    if (e.kind == 1 && kind == 1) begin
      chk("frame_len", 64'(l), 64'(e.len));
      chk("frame_data", d, e.data);
      chk("frame_which", {62'd0, wh}, {62'd0, e.which});
      chk("frame_what", {62'd0, wt}, {62'd0, e.what});
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      in_frame  = 0;
      have_prev = 0;
    end else if (ctl_enable) begin
      if (!in_frame) begin
        in_frame = 1;
        stable   = 1;
        f_len    = 0;
        f_data   = '0;
        f_which  = ctl_state_which;
        f_what   = ctl_state_what;
        if (have_prev) chk("gap_idle_cycles", 64'(low_run >= GAP + 1), 64'd1);
      end
      if (ctl_state_which != f_which || ctl_state_what != f_what) stable = 0;
      if (f_len < 64) f_data[f_len] = ctl_data;
      f_len++;
    end else begin
      if (in_frame) begin
        in_frame = 0;
        frames_seen++;
        chk("done_at_fall", {63'd0, done}, 64'd1);
        chk("sel_stable", 64'(stable), 64'd1);
        chk("sel_hold_gap", {60'd0, ctl_state_which, ctl_state_what}, {60'd0, f_which, f_what});
        pop_cmp(1, f_data, f_len, f_which, f_what);
        have_prev = 1;
        low_run   = 1;
      end else begin
        low_run++;
      end
      if (err_len) pop_cmp(2, '0, 0, '0, '0);
    end
  end

  // kind: 0 = no expectation (aborted), 1 = frame, 2 = length error
  task automatic send(input logic [31:0] d, input logic [7:0] l, input logic [1:0] wh,
                      input logic [1:0] wt, input int kind);
    exp_t e;
    int n;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_len   = l;
    cmd_which = wh;
    cmd_what  = wt;
    n = 0;
    while (n < 200) begin
      if (cmd_ready) break;
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 64'd1, 64'd0);
      cmd_valid = 1'b0;
      return;
    end
    if (kind != 0) begin
      e.kind = kind; e.data = {32'd0, d}; e.len = int'(l); e.which = wh; e.what = wt;
      q.push_back(e);
    end
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n;
    ok = 0;
    for (n = 0; n < 300; n++) begin
      @(negedge clock);
      if (done) begin ok = 1; break; end
    end
    if (!ok) chk("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clock);
      if (q.size() == 0 && !busy && !ctl_enable) break;
    end
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    bit ok;
    bit seen_full;
    int n, en_cnt, fs;
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_len = '0; cmd_which = '0; cmd_what = '0;
    @(posedge clock);
    @(negedge clock);
    chk("rst_enable", {63'd0, ctl_enable}, 64'd0);
    chk("rst_outputs", {57'd0, ctl_data, ctl_state_which, ctl_state_what, done, err_len}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

    // single 4-bit frame 0,1,1,0 with latency and busy checks
    send(32'h6, 8'd4, 2'd0, 2'd0, 1);
    @(negedge clock);
    chk("latency_not_yet", {63'd0, ctl_enable}, 64'd0);
    @(negedge clock);
    chk("latency_enable", {63'd0, ctl_enable}, 64'd1);
    chk("first_bit", {63'd0, ctl_data}, 64'd0);
    wait_done(ok);
    chk("busy_in_gap", {63'd0, busy}, 64'd1);
    @(negedge clock);
    chk("busy_after_gap", {63'd0, busy}, 64'd0);

    // one-hot bit 10 of a 16-bit frame, which=1 what=2
    send(32'h0400, 8'd16, 2'd1, 2'd2, 1);
    drain();

    // six commands back to back through a depth-4 FIFO
    fs = frames_seen;
    seen_full = 0;
    fork
      begin
        send(32'h000000A5, 8'd8, 2'd0, 2'd1, 1);
        send(32'h0000005A, 8'd8, 2'd1, 2'd2, 1);
        send(32'h000000C3, 8'd8, 2'd2, 2'd3, 1);
        send(32'h0000003C, 8'd8, 2'd3, 2'd0, 1);
        send(32'h000000F0, 8'd8, 2'd1, 2'd1, 1);
        send(32'h0000000F, 8'd8, 2'd2, 2'd2, 1);
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(negedge clock);
          if (!cmd_ready) seen_full = 1;
        end
      end
    join
    chk("ready_dropped_when_full", 64'(seen_full), 64'd1);
    drain();
    chk("six_frames_out", 64'(frames_seen - fs), 64'd6);

    // illegal lengths then a valid frame 1,1,0,0
    send(32'h12345678, 8'd0, 2'd3, 2'd3, 2);
    send(32'h12345678, 8'd33, 2'd3, 2'd3, 2);
    send(32'h3, 8'd4, 2'd2, 2'd1, 1);
    drain();

    // all-ones full width frame
    send(32'hFFFFFFFF, 8'd32, 2'd3, 2'd3, 1);
    drain();

    // reset in the middle of a frame with two commands queued
    send(32'hA5A5, 8'd16, 2'd3, 2'd1, 0);
    send(32'h1111, 8'd16, 2'd2, 2'd2, 0);
    send(32'h2222, 8'd16, 2'd1, 2'd3, 0);
    en_cnt = 0;
    for (n = 0; n < 200 && en_cnt < 5; n++) begin
      @(negedge clock);
      if (ctl_enable) en_cnt++;
    end
    chk("reached_bit5", 64'(en_cnt), 64'd5);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_enable", {63'd0, ctl_enable}, 64'd0);
    chk("abort_outputs", {57'd0, ctl_data, ctl_state_which, ctl_state_what, done, err_len}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_ready", {63'd0, cmd_ready}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("abort_no_done", {63'd0, done}, 64'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("post_reset_quiet", {62'd0, ctl_enable, done}, 64'd0);
    end
    chk("post_reset_not_busy", {63'd0, busy}, 64'd0);
    send(32'h0000_0009, 8'd5, 2'd1, 2'd3, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ola_trigger_ctl_writer.md
Name: ola_trigger_ctl_writer

Overview:
Serial configuration transmitter for the trigger's state-register load port. It accepts parallel write commands (value, bit length, target state, target register) through a valid/ready handshake and buffers them in a small FIFO. It then shifts each command out LSB-first on ctl_enable/ctl_data/ctl_state_which/ctl_state_what. It sits between the host command decoder and the trigger and replaces hand-sequenced serial loading.

Parameters:
data_width, 32, width of cmd_data; maximum serial length in bits
len_width, 8, width of cmd_len; must satisfy 2^len_width > data_width
sel_width, 2, width of state select (ctl_state_which)
reg_width, 2, width of register select (ctl_state_what)
fifo_depth, 4, command FIFO entries; power of two, >= 2
gap_cycles, 1, idle cycles forced between consecutive serial frames; >= 1

Ports:
clock  input  1  master clock; all logic on rising edge
reset  input  1  asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; a command transfers on an edge where valid&&ready
cmd_data  input  data_width  value to write; bit 0 is sent first
cmd_len  input  len_width  number of bits to send, 1..data_width
cmd_which  input  sel_width  target state index
cmd_what  input  reg_width  target register index within the state
ctl_enable  output  1  high exactly while frame bits are on ctl_data
ctl_data  output  1  serial bit; valid every cycle ctl_enable=1
ctl_state_which  output  sel_width  target state; stable for the whole frame and its gap
ctl_state_what  output  reg_width  target register; stable for the whole frame and its gap
busy  output  1  FIFO non-empty or FSM not IDLE
done  output  1  one-cycle pulse on the edge that ends a frame
err_len  output  1  one-cycle pulse when a popped command has an illegal length

Behaviour:
- Reset (async, immediate): ctl_enable=0, ctl_data=0, ctl_state_which=0, ctl_state_what=0, done=0, err_len=0, busy=0. FIFO is emptied and FSM goes to IDLE. cmd_ready=1 in the cycle after reset deasserts. A frame in progress is aborted with no completion pulse. All outputs are registered except cmd_ready and busy, which are decoded from registered state.
- FIFO:
  - cmd_ready = (count != fifo_depth).
  - Push and pop may occur on the same edge. When full, ready is low, so there is no push even if a pop occurs on that edge.
  - Order is strictly FIFO. Pointers wrap modulo fifo_depth.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If the FIFO is non-empty, pop on this edge.
  - Legal length (1..data_width): load the shift register with cmd_data and the counter with cmd_len-1. Drive ctl_data=cmd_data[0], ctl_enable=1, and which/what from the command. Go to SHIFT.
  - Illegal length (0 or >data_width): pulse err_len, send no bits, stay in IDLE. which/what are unchanged.
- Latency: a command pushed into an empty FIFO while IDLE is popped on the next edge. ctl_enable is high one cycle after the accepting edge.
- SHIFT:
  - Counter>0: shift right by one, ctl_data=next bit, counter-1.
  - Counter==0: ctl_enable=0, ctl_data=0, pulse done, load the gap counter with gap_cycles-1, go to GAP.
  - ctl_enable is high for exactly cmd_len consecutive cycles; bit i appears in the i-th enabled cycle.
- GAP: hold which/what and keep ctl_enable=0. When the gap counter reaches 0, go to IDLE. The next frame's enable therefore starts at least gap_cycles+1 cycles after the previous enable fell.
- which/what change only on a pop edge in IDLE.
- cmd_len is compared at full len_width. There is no truncation; values above data_width are errors.
- The pop while in IDLE and a push of a new command into the last free slot may occur on the same edge; both take effect.

Test Plan:
- Single command data=0x6, len=4, which=0, what=0 -> one cycle after accept, ctl_enable high 4 cycles with ctl_data 0,1,1,0; done pulses as enable falls; busy falls after the gap.
- data=0x0400, len=16, which=1, what=2 -> enable high 16 cycles, ctl_data=1 only in cycle 10 (0-based); which=1/what=2 stable through the frame and gap.
- Six commands with cmd_valid held high every cycle, depth 4 -> cmd_ready drops once 4 entries are queued; all six frames go out in order, each separated by >= gap_cycles+1 idle cycles; no command lost or duplicated.
- Commands len=0, then len=33, then data=0x3/len=4 -> two err_len pulses with no enable, then the valid frame 1,1,0,0.
- data=0xFFFFFFFF, len=32 -> 32 enabled cycles all 1; the counter boundary is handled without an extra or missing bit.
- Reset asserted mid-frame at bit 5 of 16 with 2 commands queued -> outputs 0 immediately, no done pulse, FIFO empty; after release, a new command transmits normally.
